// File: rtl/re_seq.sv
// Reuleaux-triangle sequencer: latches three arc centres and clip windows, runs the
// shared circle engine once per arc and muxes its pixels onto the VGA port. Optional screen clear: RE_SEQ_CLEAR_EN.
module re_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  diameter,
    input  logic [2:0]  colour,
    output logic        done,
    output logic        circ_start,
    output logic [11:0] circ_centre_x,
    output logic [11:0] circ_centre_y,
    output logic [7:0]  circ_radius,
    output logic [11:0] circ_x_min,
    output logic [11:0] circ_x_max,
    output logic [11:0] circ_y_min,
    output logic [11:0] circ_y_max,
    output logic [2:0]  circ_colour,
    input  logic        circ_done,
    input  logic [7:0]  circ_vga_x,
    input  logic [6:0]  circ_vga_y,
    input  logic [2:0]  circ_vga_colour,
    input  logic        circ_vga_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    typedef enum logic [3:0] {
        IDLE,
`ifdef RE_SEQ_CLEAR_EN
        CLEAR,
`endif
        CALC,
        ARC_A,
        GAP_A,
        ARC_B,
        GAP_B,
        ARC_C,
        FIN
    } state_t;

    state_t state_q, state_d;

    // Latched geometry, all 12-bit two's complement screen coordinates.
    logic [11:0] g_v1x, g_v2x, g_cx, g_vy, g_v3y;
    logic [7:0]  g_rad;
    logic [2:0]  g_col;

    // Triangle heights: 37/128 and 74/128 approximate sqrt(3)/6 and sqrt(3)/3 of d.
    logic [6:0]  h1;
    logic [7:0]  h2;
    logic [11:0] cx12, cy12, d_half;

    assign h1     = 7'(({6'd0, diameter} * 14'd37) >> 7);
    assign h2     = 8'(({7'd0, diameter} * 15'd74) >> 7);
    assign cx12   = {4'd0, centre_x};
    assign cy12   = {5'd0, centre_y};
    assign d_half = {5'd0, diameter[7:1]};

`ifdef RE_SEQ_CLEAR_EN
    logic [7:0] clr_x;
    logic [6:0] clr_y;
    logic       clr_last;

    assign clr_last = (clr_x == 8'd159) && (clr_y == 7'd119);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (state_q == CLEAR && start) begin
            if (clr_x == 8'd159) begin
                clr_x <= '0;
                clr_y <= clr_last ? 7'd0 : clr_y + 7'd1;
            end else begin
                clr_x <= clr_x + 8'd1;
            end
        end else begin
            clr_x <= '0;
            clr_y <= '0;
        end
    end
`endif

    // NOTE: reset is sampled on the clock edge, and the geometry registers are cleared too,
    // so a reset never leaves a stale arc visible on circ_radius/circ_colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_v1x   <= '0;
            g_v2x   <= '0;
            g_cx    <= '0;
            g_vy    <= '0;
            g_v3y   <= '0;
            g_rad   <= '0;
            g_col   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CALC) begin
                g_v1x <= cx12 + d_half;
                g_v2x <= cx12 - d_half;
                g_cx  <= cx12;
                g_vy  <= cy12 + {5'd0, h1};
                g_v3y <= cy12 - {4'd0, h2};
                g_rad <= diameter;
                g_col <= colour;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef RE_SEQ_CLEAR_EN
                if (start) state_d = CLEAR;
`else
                if (start) state_d = CALC;
`endif
            end
`ifdef RE_SEQ_CLEAR_EN
            CLEAR:   if (clr_last) state_d = CALC;
`endif
            CALC:    state_d = ARC_A;
            ARC_A:   if (circ_done) state_d = GAP_A;
            GAP_A:   state_d = ARC_B;
            ARC_B:   if (circ_done) state_d = GAP_B;
            GAP_B:   state_d = ARC_C;
            ARC_C:   if (circ_done) state_d = FIN;
            FIN:     state_d = FIN;
            default: state_d = IDLE;
        endcase
        // Dropping start aborts from anywhere.
        if (state_q != IDLE && !start) state_d = IDLE;
    end

    always_comb begin
        done          = (state_q == FIN);
        circ_start    = 1'b0;
        circ_centre_x = '0;
        circ_centre_y = '0;
        circ_x_min    = '0;
        circ_x_max    = '0;
        circ_y_min    = '0;
        circ_y_max    = '0;
        circ_radius   = g_rad;
        circ_colour   = g_col;
        vga_x         = '0;
        vga_y         = '0;
        vga_colour    = '0;
        vga_plot      = 1'b0;

        case (state_q)
`ifdef RE_SEQ_CLEAR_EN
            CLEAR: begin
                vga_x    = clr_x;
                vga_y    = clr_y;
                vga_plot = start;
            end
`endif
            ARC_A: begin
                circ_centre_x = g_cx;
                circ_centre_y = g_v3y;
                circ_x_min    = g_v2x - 12'd1;
                circ_x_max    = g_v1x + 12'd1;
                circ_y_min    = g_vy - 12'd1;
                circ_y_max    = 12'd120;
            end
            ARC_B: begin
                circ_centre_x = g_v1x;
                circ_centre_y = g_vy;
                circ_x_max    = g_cx + 12'd1;
                circ_y_max    = g_vy + 12'd1;
            end
            ARC_C: begin
                circ_centre_x = g_v2x;
                circ_centre_y = g_vy;
                circ_x_min    = g_cx - 12'd1;
                circ_x_max    = 12'd160;
                circ_y_max    = g_vy + 12'd1;
            end
            default: ;
        endcase

        if (state_q == ARC_A || state_q == ARC_B || state_q == ARC_C) begin
            circ_start = start;
            vga_x      = circ_vga_x;
            vga_y      = circ_vga_y;
            vga_colour = circ_vga_colour;
            vga_plot   = circ_vga_plot & start;
        end
    end

endmodule

// File: tb/tb_re_seq.sv
// Directed self-checking bench for re_seq with a small circle-engine model
// that raises circ_done a fixed number of cycles after circ_start.
module tb_re_seq;

`ifdef RE_SEQ_CLEAR_EN
    localparam int LAT   = 19202;
    localparam int PLOTS = 19200;
`else
    localparam int LAT   = 2;
    localparam int PLOTS = 0;
`endif
    localparam int ENG_N = 4;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [7:0]  centre_x;
    logic [6:0]  centre_y;
    logic [7:0]  diameter;
    logic [2:0]  colour;
    logic        done, circ_start;
    logic [11:0] circ_centre_x, circ_centre_y;
    logic [7:0]  circ_radius;
    logic [11:0] circ_x_min, circ_x_max, circ_y_min, circ_y_max;
    logic [2:0]  circ_colour;
    logic        circ_done;
    logic [7:0]  circ_vga_x;
    logic [6:0]  circ_vga_y;
    logic [2:0]  circ_vga_colour;
    logic        circ_vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int   checks = 0;
    int   failures = 0;
    int   eng_cnt = 0;
    logic eng_en = 1'b1;
    logic done_man = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (circ_start !== 1'b1) eng_cnt <= 0;
        else if (eng_cnt < ENG_N) eng_cnt <= eng_cnt + 1;
    end
    assign circ_done = eng_en ? (eng_cnt == ENG_N) : done_man;

    re_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter), .colour(colour),
        .done(done), .circ_start(circ_start),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius),
        .circ_x_min(circ_x_min), .circ_x_max(circ_x_max),
        .circ_y_min(circ_y_min), .circ_y_max(circ_y_max),
        .circ_colour(circ_colour), .circ_done(circ_done),
        .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y),
        .circ_vga_colour(circ_vga_colour), .circ_vga_plot(circ_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until circ_start rises; counts clear-style plots (colour 0) on the way.
    task automatic wait_rise(output int n, output int plots);
        n = 0;
        plots = 0;
        do begin
            step();
            n++;
            if (vga_plot === 1'b1 && vga_colour === 3'd0 && circ_start !== 1'b1) plots++;
        end while (circ_start !== 1'b1 && n < 30000);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (circ_start === 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_cstart"}, circ_start, 0);
        check({tag, "_plot"}, vga_plot, 0);
        check({tag, "_vxyc"}, {vga_x, vga_y, vga_colour}, 0);
    endtask

    task automatic check_geom(input string tag, input logic [11:0] cx, input logic [11:0] cy,
                              input logic [11:0] xmn, input logic [11:0] xmx,
                              input logic [11:0] ymn, input logic [11:0] ymx);
        check({tag, "_cx"}, circ_centre_x, cx);
        check({tag, "_cy"}, circ_centre_y, cy);
        check({tag, "_xmin"}, circ_x_min, xmn);
        check({tag, "_xmax"}, circ_x_max, xmx);
        check({tag, "_ymin"}, circ_y_min, ymn);
        check({tag, "_ymax"}, circ_y_max, ymx);
    endtask

    int n, plots;

    initial begin
        rst_n = 1'b0; start = 1'b0;
        centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80; colour = 3'd5;
        circ_vga_x = 8'd33; circ_vga_y = 7'd44; circ_vga_colour = 3'd6; circ_vga_plot = 1'b1;
        step();
        step();
        check_idle_zero("reset");
        check("reset_rad", circ_radius, 0);
        rst_n = 1'b1;
        step();
        check_idle_zero("idle");

        // Full run: cx=80 cy=60 d=80 -> v1=(120,83) v2=(40,83) v3=(80,14).
        start = 1'b1;
        wait_rise(n, plots);
        check("lat1", n, LAT);
        check("clear_plots1", plots, PLOTS);
        check_geom("arcA", 12'd80, 12'd14, 12'd39, 12'd121, 12'd82, 12'd120);
        check("arcA_rad", circ_radius, 8'd80);
        check("arcA_col", circ_colour, 3'd5);
        check("arcA_vga", {vga_x, vga_y, vga_colour, vga_plot}, {8'd33, 7'd44, 3'd6, 1'b1});
        check("arcA_done", done, 0);
        wait_fall(n);
        check("arcA_len", n, ENG_N + 1);
        check("gapA_plot", vga_plot, 0);
        step();
        check("gapA_len", circ_start, 1);
        check_geom("arcB", 12'd120, 12'd83, 12'd0, 12'd81, 12'd0, 12'd84);
        circ_vga_x = 8'd7; circ_vga_y = 7'd100; circ_vga_colour = 3'd1;
        #1;
        check("arcB_vga", {vga_x, vga_y, vga_colour, vga_plot}, {8'd7, 7'd100, 3'd1, 1'b1});
        wait_fall(n);
        check("arcB_len", n, ENG_N + 1);
        step();
        check("gapB_len", circ_start, 1);
        check_geom("arcC", 12'd40, 12'd83, 12'd79, 12'd160, 12'd0, 12'd84);
        wait_fall(n);
        check("arcC_len", n, ENG_N + 1);
        check("fin_done", done, 1);
        check("fin_plot", vga_plot, 0);
        step();
        step();
        check("fin_hold", done, 1);
        check("fin_cstart", circ_start, 0);
        start = 1'b0;
        step();
        check_idle_zero("fin_exit");

        // Abort during ARC_B: cx=20 cy=100 d=40 -> v1=(40,111) v2=(0,111) v3=(20,77).
        centre_x = 8'd20; centre_y = 7'd100; diameter = 8'd40; colour = 3'd2;
        start = 1'b1;
        wait_rise(n, plots);
        check("lat2", n, LAT);
        check_geom("arcA2", 12'd20, 12'd77, 12'hFFF, 12'd41, 12'd110, 12'd120);
        wait_fall(n);
        step();
        check_geom("arcB2", 12'd40, 12'd111, 12'd0, 12'd21, 12'd0, 12'd112);
        start = 1'b0;
        #1;
        check("abort_cstart_now", circ_start, 0);
        check("abort_plot_now", vga_plot, 0);
        step();
        check_idle_zero("abort_idle");
        step();
        check("abort_stay", circ_start, 0);

        // Restart with fresh geometry: cx=100 cy=30 d=20 -> v1=(110,35) v2=(90,35) v3=(100,19).
        centre_x = 8'd100; centre_y = 7'd30; diameter = 8'd20; colour = 3'd7;
        start = 1'b1;
        wait_rise(n, plots);
        check("lat3", n, LAT);
        check_geom("arcA3", 12'd100, 12'd19, 12'd89, 12'd111, 12'd34, 12'd120);
        check("arcA3_rad", circ_radius, 8'd20);
        check("arcA3_col", circ_colour, 3'd7);
        start = 1'b0;
        step();

        // circ_done held high outside arc states must not advance the sequence.
        eng_en = 1'b0;
        done_man = 1'b1;
        step();
        check("ign_idle", circ_start, 0);
        start = 1'b1;
        wait_rise(n, plots);
        check("ign_lat", n, LAT);

        // Reset while in an arc, start still high.
        rst_n = 1'b0;
        step();
        check_idle_zero("rst_arc");
        check("rst_arc_geom", {circ_radius, circ_colour}, 0);
        eng_en = 1'b1;
        done_man = 1'b0;
        rst_n = 1'b1;
`ifdef RE_SEQ_CLEAR_EN
        step();
        check("clr0_pix", {vga_x, vga_y, vga_colour, vga_plot}, {8'd0, 7'd0, 3'd0, 1'b1});
        for (int i = 0; i < 299; i++) step();
        check("clr299_pix", {vga_x, vga_y}, {8'd139, 7'd1});
        rst_n = 1'b0;
        step();
        check_idle_zero("rst_clear");
        rst_n = 1'b1;
`endif
        wait_rise(n, plots);
        check("lat4", n, LAT);
        check("clear_plots4", plots, PLOTS);
        check_geom("arcA4", 12'd100, 12'd19, 12'd89, 12'd111, 12'd34, 12'd120);
        start = 1'b0;
        step();
        check_idle_zero("end_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/re_seq.md
RE_SEQ -- requirements
Module: re_seq

Reuleaux-triangle sequencer: computes three arc centres and clip windows, runs the shared circle engine three times, and muxes its pixel stream onto the VGA port.

Interface
REQ-001 clk  in  1  system clock; every state change occurs on its rising edge.
REQ-002 rst_n  in  1  reset rst_n, synchronous, active-low; clock clk.
REQ-003 start  in  1  level request; held high for the whole operation.
REQ-004 centre_x  in  8  triangle centre X, pixels 0..159.
REQ-005 centre_y  in  7  triangle centre Y, pixels 0..119.
REQ-006 diameter  in  8  side length d, also the arc radius.
REQ-007 colour  in  3  drawing colour.
REQ-008 done  out  1  high once all arcs are drawn; held until start falls.
REQ-009 circ_start  out  1  level start to the circle engine.
REQ-010 circ_centre_x / circ_centre_y  out  12 each  arc centre, two's complement.
REQ-011 circ_radius  out  8  equals diameter.
REQ-012 circ_x_min / circ_x_max / circ_y_min / circ_y_max  out  12 each  exclusive clip bounds.
REQ-013 circ_colour  out  3  equals latched colour.
REQ-014 circ_done  in  1  engine completion level.
REQ-015 circ_vga_x[7:0] / circ_vga_y[6:0] / circ_vga_colour[3] / circ_vga_plot[1]  in  engine pixel stream.
REQ-016 vga_x[7:0] / vga_y[6:0] / vga_colour[3] / vga_plot[1]  out  muxed pixel port.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, CALC, ARC_A, GAP_A, ARC_B, GAP_B, ARC_C, FIN.
- IDLE: while start is low, stays in IDLE with done=0.
- On start=1, moves to CLEAR; if CLEAR is compiled out, moves directly to CALC.
REQ-018 CALC SHALL take one cycle and latch d, colour and these vertices (h1 = (d*37)>>7, h2 = (d*74)>>7, 12-bit two's-complement wrap):
- v1 = (cx + d/2, cy + h1)
- v2 = (cx - d/2, cy + h1)
- v3 = (cx, cy - h2)
REQ-019 ARC_A SHALL drive the following until the cycle circ_done=1 is sampled, then go to GAP_A:
- centre = v3
- x_min = v2.x - 1, x_max = v1.x + 1
- y_min = v1.y - 1, y_max = 120
REQ-020 ARC_B SHALL use centre = v1, x_min = 0, x_max = cx + 1, y_min = 0, y_max = v1.y + 1.
REQ-021 ARC_C SHALL use centre = v2, x_min = cx - 1, x_max = 160, y_min = 0, y_max = v1.y + 1.
REQ-022 circ_start SHALL be 1 only in ARC_A/B/C and 0 for exactly one cycle in GAP_A/GAP_B, so the engine re-initialises between arcs.
REQ-023 After ARC_C sees circ_done=1, the FSM SHALL enter FIN, where done=1, circ_start=0 and vga_plot=0.
REQ-024 From FIN, start=0 SHALL return the FSM to IDLE and clear done in the next cycle.
REQ-025 During ARC states, vga_* SHALL equal circ_vga_* combinationally.
REQ-026 In all other states except CLEAR, vga_plot SHALL be 0.
REQ-027 start falling in any non-IDLE state SHALL abort the operation:
- next state IDLE; circ_start=0 and vga_plot=0 from that cycle.
REQ-028 circ_done asserted outside ARC states SHALL be ignored.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force the following, overriding all other inputs including mid-arc and mid-clear:
- state IDLE
- done=0, circ_start=0, vga_plot=0
- vga_x=0, vga_y=0, vga_colour=0
- clear counters = 0
- all latched geometry = 0

Configuration
REQ-030 Macro RE_SEQ_CLEAR_EN: when defined, CLEAR sweeps x 0..159 (inner) and y 0..119 (outer), one pixel per cycle:
- vga_plot=1, vga_colour=0
- exactly 19200 cycles, then CALC
REQ-031 When RE_SEQ_CLEAR_EN is undefined, CLEAR and its counters SHALL be absent and IDLE SHALL go directly to CALC.

Verification
REQ-032 start=1, cx=80, cy=60, d=80 -> CALC latches v1=(120,83), v2=(40,83), v3=(80,14); ARC_A drives centre (80,14) with clip bounds (39,121,82,120).
REQ-033 Engine model asserting circ_done after N cycles per arc -> three circ_start pulses, each separated by a single low cycle; done=1 after the third; done held while start=1.
REQ-034 start dropped during ARC_B -> next cycle state IDLE, circ_start=0, vga_plot=0; a new start restarts from CLEAR/CALC with fresh geometry.
REQ-035 rst_n=0 for one cycle mid-CLEAR (defined build) -> all outputs zero; after release with start=1, the sweep restarts at (0,0).
REQ-036 RE_SEQ_CLEAR_EN defined -> exactly 19200 plot cycles with colour 0 before the first circ_start; undefined -> circ_start rises 2 cycles after start.
